// File: rtl/switch_ingress_framer.sv
// switch_ingress_framer: store-and-forward ingress buffer in front of a switch
// port; releases only complete, well-formed sop/eop packets.
module switch_ingress_framer #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       in_data,
    input  logic                    in_sop,
    input  logic                    in_eop,
    output logic                    in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic                    out_sop,
    output logic                    out_eop,
    input  logic                    out_ready,
    output logic [$clog2(DEPTH):0]  pkt_cnt,
    output logic [CNT_W-1:0]        drop_cnt,
    output logic [CNT_W-1:0]        err_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
    localparam logic [PW-1:0] ONE_P   = PW'(1);

    typedef enum logic [1:0] { W_IDLE, W_PKT, W_DROP } w_state_e;
    typedef enum logic       { R_IDLE, R_SEND }        r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     cm_ptr_q, cm_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              commit_q, commit_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sop_q, out_sop_d;
    logic              out_eop_q, out_eop_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    logic [DATA_W:0]   mem_q [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W:0]   rd_word;
    logic              accept, ovf, err_inc, drop_inc;
    logic              pkt_dec, load, load_sop;
    logic              full_n, ovf_n;

    // The open packet alone fills the buffer: it can never fit, so drop it.
    assign accept = in_valid & in_ready_q;
    assign ovf    = (w_state_q == W_PKT) && ((wr_ptr_q - cm_ptr_q) == DEPTH_P);

    always_comb begin
        w_state_d = w_state_q;
        wr_ptr_d  = wr_ptr_q;
        cm_ptr_d  = cm_ptr_q;
        commit_d  = 1'b0;
        mem_we    = 1'b0;
        mem_waddr = wr_ptr_q[AW-1:0];
        err_inc   = 1'b0;
        drop_inc  = 1'b0;
        if (accept) begin
            unique case (w_state_q)
                W_IDLE: begin
                    if (in_sop) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (in_eop) begin
                            cm_ptr_d = wr_ptr_q + ONE_P;
                            commit_d = 1'b1;
                        end else begin
                            w_state_d = W_PKT;
                        end
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                W_PKT: begin
                    if (in_sop) begin
                        err_inc   = 1'b1;
                        mem_we    = 1'b1;
                        mem_waddr = cm_ptr_q[AW-1:0];
                        wr_ptr_d  = cm_ptr_q + ONE_P;
                        if (in_eop) begin
                            cm_ptr_d  = cm_ptr_q + ONE_P;
                            commit_d  = 1'b1;
                            w_state_d = W_IDLE;
                        end
                    end else if (ovf) begin
                        wr_ptr_d  = cm_ptr_q;
                        drop_inc  = 1'b1;
                        w_state_d = in_eop ? W_IDLE : W_DROP;
                    end else begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ONE_P;
                        if (in_eop) begin
                            cm_ptr_d  = wr_ptr_q + ONE_P;
                            commit_d  = 1'b1;
                            w_state_d = W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if (in_eop) w_state_d = W_IDLE;
                end
                default: w_state_d = W_IDLE;
            endcase
        end
    end

    assign rd_word = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        r_state_d   = r_state_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_sop_d   = out_sop_q;
        out_eop_d   = out_eop_q;
        out_data_d  = out_data_q;
        pkt_dec     = 1'b0;
        load        = 1'b0;
        load_sop    = 1'b0;
        unique case (r_state_q)
            R_IDLE: begin
                if (pkt_cnt_q != '0) begin
                    load      = 1'b1;
                    load_sop  = 1'b1;
                    r_state_d = R_SEND;
                end
            end
            R_SEND: begin
                if (out_valid_q && out_ready) begin
                    if (out_eop_q) begin
                        pkt_dec = 1'b1;
                        if (pkt_cnt_q > ONE_P) begin
                            load     = 1'b1;
                            load_sop = 1'b1;
                        end else begin
                            out_valid_d = 1'b0;
                            out_sop_d   = 1'b0;
                            out_eop_d   = 1'b0;
                            r_state_d   = R_IDLE;
                        end
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        if (load) begin
            out_valid_d = 1'b1;
            out_sop_d   = load_sop;
            out_eop_d   = rd_word[DATA_W];
            out_data_d  = rd_word[DATA_W-1:0];
            rd_ptr_d    = rd_ptr_q + ONE_P;
        end
    end

    // Commit reaches pkt_cnt one cycle after the eop edge.
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (commit_q && !pkt_dec) pkt_cnt_d = pkt_cnt_q + ONE_P;
        else if (!commit_q && pkt_dec) pkt_cnt_d = pkt_cnt_q - ONE_P;
        drop_cnt_d = drop_cnt_q;
        if (drop_inc && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
        err_cnt_d = err_cnt_q;
        if (err_inc && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        full_n = (wr_ptr_d - rd_ptr_d) == DEPTH_P;
        ovf_n  = (w_state_d == W_PKT) && ((wr_ptr_d - cm_ptr_d) == DEPTH_P);
        in_ready_d = (w_state_d == W_DROP) || !full_n || ovf_n;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[mem_waddr] <= {in_eop, in_data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_ptr_q    <= '0;
            cm_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            pkt_cnt_q   <= '0;
            drop_cnt_q  <= '0;
            err_cnt_q   <= '0;
            commit_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_ptr_q    <= wr_ptr_d;
            cm_ptr_q    <= cm_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            pkt_cnt_q   <= pkt_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_cnt_q   <= err_cnt_d;
            commit_q    <= commit_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_sop_q   <= out_sop_d;
            out_eop_q   <= out_eop_d;
            out_data_q  <= out_data_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_data  = out_data_q;
    assign pkt_cnt   = pkt_cnt_q;
    assign drop_cnt  = drop_cnt_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_switch_ingress_framer.sv
// tb_switch_ingress_framer: randomized packet streams checked against a
// packet-level model of the framing, overflow and release rules.
module tb_switch_ingress_framer;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int PW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          in_sop = 1'b0;
    logic          in_eop = 1'b0;
    logic          in_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          out_sop;
    logic          out_eop;
    logic          out_ready = 1'b0;
    logic [PW-1:0] pkt_cnt;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;
    int stalls = 0;
    int cyc = 0;
    int rdy_mode = 0;
    bit gaps = 0;

    // beat = {sop, eop, data}
    logic [DW+1:0] stim[$];
    logic [DW+1:0] exp_q[$];
    logic [DW+1:0] got_q[$];
    int            got_cyc[$];
    int            exp_err;
    int            exp_drop;

    logic          hold_v = 1'b0;
    logic [DW+1:0] hold_b;

    switch_ingress_framer #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data),
        .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_ready(out_ready),
        .pkt_cnt(pkt_cnt), .drop_cnt(drop_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0: out_ready = 1'b1;
            1: out_ready = 1'b0;
            2: out_ready = ~out_ready;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Output collector plus hold-until-accepted protocol check.
    always @(negedge clk) begin
        if (!reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                checks++;
                if (!out_valid || {out_sop, out_eop, out_data} !== hold_b) begin
                    errors++;
                    $display("FAIL out_hold got v=%0b %h required v=1 %h",
                             out_valid, {out_sop, out_eop, out_data}, hold_b);
                end
            end
            hold_v = out_valid && !out_ready;
            hold_b = {out_sop, out_eop, out_data};
            if (out_valid && out_ready) begin
                got_q.push_back({out_sop, out_eop, out_data});
                got_cyc.push_back(cyc);
            end
        end
    end

    task automatic build_model();
        logic [DW-1:0] cur[$];
        bit inpkt, dropping, s, e;
        inpkt = 0;
        dropping = 0;
        exp_q.delete();
        exp_err = 0;
        exp_drop = 0;
        foreach (stim[i]) begin
            s = stim[i][DW+1];
            e = stim[i][DW];
            if (dropping) begin
                if (e) dropping = 0;
                continue;
            end
            if (s) begin
                if (inpkt) exp_err++;
                cur.delete();
                inpkt = 1;
            end else if (!inpkt) begin
                exp_err++;
                continue;
            end
            cur.push_back(stim[i][DW-1:0]);
            if (cur.size() > DEPTH) begin
                exp_drop++;
                inpkt = 0;
                dropping = !e;
                cur.delete();
                continue;
            end
            if (e) begin
                foreach (cur[k])
                    exp_q.push_back({1'(k == 0), 1'(k == cur.size() - 1), cur[k]});
                inpkt = 0;
                cur.delete();
            end
        end
    endtask

    task automatic drive_beat(input logic [DW+1:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        {in_sop, in_eop, in_data} = b;
        do begin
            @(negedge clk);
            if (!in_ready) stalls++;
            t++;
        end while (!in_ready && t < 400);
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout got 0 required 1");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_stim();
        foreach (stim[i]) begin
            drive_beat(stim[i]);
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int t;
        t = 0;
        while ((got_q.size() < exp_q.size() || pkt_cnt !== '0 || out_valid) && t < 3000) begin
            @(posedge clk);
            #1;
            t++;
        end
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() < exp_q.size() || pkt_cnt !== '0 || out_valid) begin
            errors++;
            $display("FAIL %s_drain got %0d beats required %0d", name, got_q.size(), exp_q.size());
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        got_q.delete();
        got_cyc.delete();
        stim.delete();
        stalls = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, in_ready} !== 4'b0) begin
            errors++;
            $display("FAIL rst_flags got %b required 0000", {out_valid, out_sop, out_eop, in_ready});
        end
        checks++;
        if (out_data !== '0) begin
            errors++;
            $display("FAIL rst_data got %h required 00", out_data);
        end
        checks++;
        if ({pkt_cnt, drop_cnt, err_cnt} !== '0) begin
            errors++;
            $display("FAIL rst_cnts got %0d/%0d/%0d required 0/0/0", pkt_cnt, drop_cnt, err_cnt);
        end
        do_reset();
    endtask

    task automatic test_basic();
        rdy_mode = 0;
        do_reset();
        for (int i = 0; i < 4; i++)
            stim.push_back({1'(i == 0), 1'(i == 3), 8'($urandom)});
        build_model();
        send_stim();
        checks++;
        if (pkt_cnt !== '0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_e0 got cnt=%0d v=%0b required 0 0", pkt_cnt, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (pkt_cnt !== PW'(1) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL lat_e1 got cnt=%0d v=%0b required 1 0", pkt_cnt, out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, out_data} !== {1'b1, exp_q[0]}) begin
            errors++;
            $display("FAIL lat_e2 got %h required %h",
                     {out_valid, out_sop, out_eop, out_data}, {1'b1, exp_q[0]});
        end
        wait_drain("basic");
        checks++;
        if (got_q.size() != 4) begin
            errors++;
            $display("FAIL basic_len got %0d required 4", got_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
        if (got_cyc.size() == 4) begin
            checks++;
            if (got_cyc[3] - got_cyc[0] != 3) begin
                errors++;
                $display("FAIL basic_consec got span %0d required 3", got_cyc[3] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_one_beat();
        rdy_mode = 0;
        do_reset();
        stim.push_back({2'b11, 8'h5A});
        build_model();
        send_stim();
        wait_drain("one");
        checks++;
        if (got_q.size() != 1 || got_q[0] !== {2'b11, 8'h5A}) begin
            errors++;
            $display("FAIL one_beat got n=%0d b=%h required n=1 b=35a",
                     got_q.size(), got_q.size() ? got_q[0] : '0);
        end
    endtask

    task automatic test_overflow();
        rdy_mode = 1;
        do_reset();
        for (int i = 0; i < 20; i++)
            stim.push_back({1'(i == 0), 1'(i == 19), 8'($urandom)});
        build_model();
        send_stim();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (stalls != 0) begin
            errors++;
            $display("FAIL ovf_ready got %0d stalls required 0", stalls);
        end
        checks++;
        if (drop_cnt !== CW'(exp_drop) || pkt_cnt !== '0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL ovf_cnts got d=%0d p=%0d e=%0d required d=%0d p=0 e=0",
                     drop_cnt, pkt_cnt, err_cnt, exp_drop);
        end
        rdy_mode = 0;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (got_q.size() != 0 || out_valid) begin
            errors++;
            $display("FAIL ovf_out got %0d beats required 0", got_q.size());
        end
    endtask

    task automatic test_sop_error();
        rdy_mode = 0;
        do_reset();
        stim.push_back({2'b10, 8'hB0});
        stim.push_back({2'b00, 8'hB1});
        stim.push_back({2'b10, 8'hC0});
        stim.push_back({2'b00, 8'hC1});
        stim.push_back({2'b01, 8'hC2});
        build_model();
        send_stim();
        wait_drain("soperr");
        checks++;
        if (err_cnt !== CW'(exp_err) || got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL soperr_cnt got e=%0d n=%0d required e=%0d n=%0d",
                     err_cnt, got_q.size(), exp_err, exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL soperr_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_stray();
        rdy_mode = 0;
        do_reset();
        stim.push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
        build_model();
        send_stim();
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (err_cnt !== CW'(exp_err) || pkt_cnt !== '0 || got_q.size() != 0) begin
            errors++;
            $display("FAIL stray got e=%0d p=%0d n=%0d required e=%0d p=0 n=0",
                     err_cnt, pkt_cnt, got_q.size(), exp_err);
        end
    endtask

    task automatic test_back_to_back();
        rdy_mode = 2;
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < DEPTH; i++)
                stim.push_back({1'(i == 0), 1'(i == DEPTH - 1), 8'($urandom)});
        build_model();
        send_stim();
        wait_drain("b2b");
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL b2b_stall got 0 stall cycles required >0");
        end
        checks++;
        if (got_q.size() != 2 * DEPTH || drop_cnt !== '0) begin
            errors++;
            $display("FAIL b2b_len got n=%0d d=%0d required n=%0d d=0",
                     got_q.size(), drop_cnt, 2 * DEPTH);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL b2b_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int len, kind;
        rdy_mode = 3;
        do_reset();
        gaps = 1;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 20);
            kind = (p == 39) ? 5 : $urandom_range(0, 9);
            if (kind == 0) stim.push_back({1'b0, 1'($urandom_range(0, 1)), 8'($urandom)});
            for (int i = 0; i < len; i++)
                stim.push_back({1'(i == 0), 1'(i == len - 1 && kind != 1), 8'($urandom)});
        end
        build_model();
        send_stim();
        gaps = 0;
        wait_drain("rand");
        checks++;
        if (err_cnt !== CW'(exp_err) || drop_cnt !== CW'(exp_drop)) begin
            errors++;
            $display("FAIL rand_cnts got e=%0d d=%0d required e=%0d d=%0d",
                     err_cnt, drop_cnt, exp_err, exp_drop);
        end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++;
            $display("FAIL rand_len got %0d required %0d", got_q.size(), exp_q.size());
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_mid();
        int t;
        rdy_mode = 1;
        do_reset();
        for (int i = 0; i < 8; i++)
            stim.push_back({1'(i == 0), 1'(i == 7), 8'($urandom)});
        send_stim();
        repeat (4) @(posedge clk);
        #1;
        rdy_mode = 0;
        t = 0;
        while (!(out_valid && got_q.size() >= 2) && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        checks++;
        if (!(out_valid && got_q.size() >= 2)) begin
            errors++;
            $display("FAIL rstmid_start got v=%0b n=%0d required v=1 n>=2", out_valid, got_q.size());
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, out_sop, out_eop, in_ready, out_data, pkt_cnt} !== '0) begin
            errors++;
            $display("FAIL rstmid_async got v=%0b s=%0b e=%0b r=%0b d=%h p=%0d required all 0",
                     out_valid, out_sop, out_eop, in_ready, out_data, pkt_cnt);
        end
        do_reset();
        for (int i = 0; i < 5; i++)
            stim.push_back({1'(i == 0), 1'(i == 4), 8'($urandom)});
        build_model();
        send_stim();
        wait_drain("rstmid");
        checks++;
        if (got_q.size() != 5 || err_cnt !== '0 || drop_cnt !== '0) begin
            errors++;
            $display("FAIL rstmid_after got n=%0d e=%0d d=%0d required n=5 e=0 d=0",
                     got_q.size(), err_cnt, drop_cnt);
        end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            checks++;
            if (got_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rstmid_beat%0d got %h required %h", i, got_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_one_beat();
        test_overflow();
        test_sop_error();
        test_stray();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
